// File: rtl/alu_stage_pkg.sv
// Shared types and default sizes for the ALU result stage and its testbench.
package alu_stage_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_RA_W  = 5;
    localparam int DEF_CNT_W = 16;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Bundle of the ALU result stage handshake and data signals.
// valid/ready: a transfer happens on a rising edge where both are high; the
// sender holds its payload stable while valid is high and ready is low.
import alu_stage_pkg::*;

interface alu_result_stage_if #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int RA_W  = DEF_RA_W,
    parameter int CNT_W = DEF_CNT_W
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic [RA_W-1:0]  in_rd;
    logic             in_we;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [RA_W-1:0]  out_rd;
    logic             out_we;
    logic             out_zero;
    logic             out_neg;
    logic [CNT_W-1:0] retire_cnt;
    state_t           dbg_state;

    modport master (
        output flush, in_valid, in_result, in_rd, in_we, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_we,
               out_zero, out_neg, retire_cnt, dbg_state
    );

    modport slave (
        input  flush, in_valid, in_result, in_rd, in_we, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_we,
               out_zero, out_neg, retire_cnt, dbg_state
    );

endinterface

// File: rtl/result_flags.sv
// Zero and sign flags of a WIDTH-bit value, purely combinational.
import alu_stage_pkg::*;

module result_flags #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    output logic             zero,
    output logic             neg
);

    assign zero = (value == '0);
    assign neg  = value[WIDTH-1];

endmodule

// File: rtl/alu_result_stage.sv
// Two-entry skid buffer between the ALU and register-file writeback, with
// push-time flags and a saturating retire counter.
import alu_stage_pkg::*;

module alu_result_stage #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int RA_W  = DEF_RA_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [RA_W-1:0]  in_rd,
    input  logic             in_we,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [RA_W-1:0]  out_rd,
    output logic             out_we,
    output logic             out_zero,
    output logic             out_neg,
    output logic [CNT_W-1:0] retire_cnt,
    output state_t           dbg_state
);

    state_t state, state_nx;

    logic push, pop;
    logic load_main, move_skid, load_skid, count_pop;
    logic flag_zero, flag_neg, we_eff;

    logic [WIDTH-1:0] main_result, skid_result;
    logic [RA_W-1:0]  main_rd, skid_rd;
    logic             main_we, skid_we;
    logic             main_zero, skid_zero;
    logic             main_neg, skid_neg;

    result_flags #(.WIDTH(WIDTH)) u_flags (
        .value (in_result),
        .zero  (flag_zero),
        .neg   (flag_neg)
    );

    // Writes to r0 are dropped at entry so the held enable is already final.
    assign we_eff = in_we && (in_rd != '0);

    // Ready depends on occupancy only, breaking any path from out_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count_pop = pop && !flush;

    always_comb begin
        state_nx  = state;
        load_main = 1'b0;
        move_skid = 1'b0;
        load_skid = 1'b0;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        state_nx  = ONE;
                        load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        load_main = 1'b1;
                    end else if (push) begin
                        state_nx  = FULL;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_nx  = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_nx  = ONE;
                        move_skid = 1'b1;
                    end
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_result <= '0;
            main_rd     <= '0;
            main_we     <= 1'b0;
            main_zero   <= 1'b0;
            main_neg    <= 1'b0;
        end else if (load_main) begin
            main_result <= in_result;
            main_rd     <= in_rd;
            main_we     <= we_eff;
            main_zero   <= flag_zero;
            main_neg    <= flag_neg;
        end else if (move_skid) begin
            main_result <= skid_result;
            main_rd     <= skid_rd;
            main_we     <= skid_we;
            main_zero   <= skid_zero;
            main_neg    <= skid_neg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_result <= '0;
            skid_rd     <= '0;
            skid_we     <= 1'b0;
            skid_zero   <= 1'b0;
            skid_neg    <= 1'b0;
        end else if (load_skid) begin
            skid_result <= in_result;
            skid_rd     <= in_rd;
            skid_we     <= we_eff;
            skid_zero   <= flag_zero;
            skid_neg    <= flag_neg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= '0;
        end else if (count_pop && (retire_cnt != '1)) begin
            retire_cnt <= retire_cnt + 1'b1;
        end
    end

    // Reset clears the main register, so the outputs read zero while in reset.
    assign out_result = main_result;
    assign out_rd     = main_rd;
    assign out_we     = main_we;
    assign out_zero   = main_zero;
    assign out_neg    = main_neg;
    assign dbg_state  = state;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: vector table, scoreboard, and
// hand-written saturation and asynchronous-reset sequences.
import alu_stage_pkg::*;

module tb_alu_result_stage;

    logic clk;
    logic rst_n;

    alu_result_stage_if #(.WIDTH(32), .RA_W(5), .CNT_W(16)) bus ();

    // Narrow-counter instance shares all stimulus with the main one.
    logic             s_in_ready, s_out_valid, s_out_we, s_out_zero, s_out_neg;
    logic [31:0]      s_out_result;
    logic [4:0]       s_out_rd;
    logic [3:0]       s_retire_cnt;
    state_t           s_state;

    alu_result_stage #(.WIDTH(32), .RA_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(bus.flush),
        .in_valid(bus.in_valid), .in_ready(bus.in_ready),
        .in_result(bus.in_result), .in_rd(bus.in_rd), .in_we(bus.in_we),
        .out_valid(bus.out_valid), .out_ready(bus.out_ready),
        .out_result(bus.out_result), .out_rd(bus.out_rd), .out_we(bus.out_we),
        .out_zero(bus.out_zero), .out_neg(bus.out_neg),
        .retire_cnt(bus.retire_cnt), .dbg_state(bus.dbg_state)
    );

    alu_result_stage #(.WIDTH(32), .RA_W(5), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .flush(bus.flush),
        .in_valid(bus.in_valid), .in_ready(s_in_ready),
        .in_result(bus.in_result), .in_rd(bus.in_rd), .in_we(bus.in_we),
        .out_valid(s_out_valid), .out_ready(bus.out_ready),
        .out_result(s_out_result), .out_rd(s_out_rd), .out_we(s_out_we),
        .out_zero(s_out_zero), .out_neg(s_out_neg),
        .retire_cnt(s_retire_cnt), .dbg_state(s_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          exp_cnt;
    int          checks;
    int          errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; applies inputs for one rising edge and
    // returns at the next falling edge.
    task automatic step(input logic iv, input logic [31:0] res, input logic [4:0] rd,
                        input logic we, input logic ordy, input logic fl);
        logic m_ready, m_push, m_pop;
        int   sat;
        bus.in_valid  = iv;
        bus.in_result = res;
        bus.in_rd     = rd;
        bus.in_we     = we;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #1;
        m_ready = (exp_q.size() < 2);
        m_push  = iv && m_ready;
        m_pop   = (exp_q.size() != 0) && ordy;
        chk("sb_in_ready", {63'd0, bus.in_ready}, {63'd0, m_ready});
        chk("sb_out_valid", {63'd0, bus.out_valid}, {63'd0, exp_q.size() != 0});
        if (fl) begin
            exp_q.delete();
        end else begin
            if (m_pop) begin
                chk("sb_order", {32'd0, bus.out_result}, {32'd0, exp_q[0]});
                void'(exp_q.pop_front());
                exp_cnt++;
            end
            if (m_push) exp_q.push_back(res);
        end
        @(posedge clk);
        @(negedge clk);
        sat = (exp_cnt > 15) ? 15 : exp_cnt;
        chk("retire_cnt", {48'd0, bus.retire_cnt}, exp_cnt);
        chk("retire_cnt_w4", {60'd0, s_retire_cnt}, sat);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        iv;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
        logic        ordy;
        logic        fl;
        logic        e_valid;
        logic [31:0] e_res;
        logic [4:0]  e_rd;
        logic        e_we;
        logic        e_zero;
        logic        e_neg;
        logic        e_ready;
        state_t      e_state;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // iv res rd we ordy fl | valid res rd we zero neg in_ready state
        vecs[0]  = '{1'b1, 32'h0000_0000, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, ONE};
        vecs[1]  = '{1'b0, 32'h0000_0000, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, EMPTY};
        vecs[2]  = '{1'b1, 32'h8000_0001, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0001, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, ONE};
        vecs[3]  = '{1'b1, 32'h0000_00FF, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0001, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, FULL};
        vecs[4]  = '{1'b1, 32'h1234_5678, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0001, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, FULL};
        vecs[5]  = '{1'b0, 32'h0000_0000, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_00FF, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, ONE};
        vecs[6]  = '{1'b0, 32'h0000_0000, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, EMPTY};
        vecs[7]  = '{1'b1, 32'h0000_0007, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0007, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, ONE};
        vecs[8]  = '{1'b1, 32'h0000_0010, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, ONE};
        vecs[9]  = '{1'b1, 32'hFFFF_FFFF, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, FULL};
        vecs[10] = '{1'b1, 32'h0000_AAAA, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, EMPTY};
        vecs[11] = '{1'b0, 32'h0000_0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, EMPTY};
    end

    // ---------------- test sequence ----------------
    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 0;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_result = 32'hDEAD_BEEF;
        bus.in_rd     = 5'd9;
        bus.in_we     = 1'b1;
        bus.out_ready = 1'b0;

        // Reset state, with a push attempted across a clock edge.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_out_result", {32'd0, bus.out_result}, 64'd0);
        chk("rst_retire_cnt", {48'd0, bus.retire_cnt}, 64'd0);
        chk("rst_state", {62'd0, bus.dbg_state}, {62'd0, EMPTY});
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].iv, vecs[i].res, vecs[i].rd, vecs[i].we, vecs[i].ordy, vecs[i].fl);
            chk($sformatf("v%0d_out_valid", i), {63'd0, bus.out_valid}, {63'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_in_ready", i), {63'd0, bus.in_ready}, {63'd0, vecs[i].e_ready});
            chk($sformatf("v%0d_state", i), {62'd0, bus.dbg_state}, {62'd0, vecs[i].e_state});
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_out_result", i), {32'd0, bus.out_result}, {32'd0, vecs[i].e_res});
                chk($sformatf("v%0d_out_rd", i), {59'd0, bus.out_rd}, {59'd0, vecs[i].e_rd});
                chk($sformatf("v%0d_out_we", i), {63'd0, bus.out_we}, {63'd0, vecs[i].e_we});
                chk($sformatf("v%0d_out_zero", i), {63'd0, bus.out_zero}, {63'd0, vecs[i].e_zero});
                chk($sformatf("v%0d_out_neg", i), {63'd0, bus.out_neg}, {63'd0, vecs[i].e_neg});
            end
        end
        chk("after_table_cnt", {48'd0, bus.retire_cnt}, 64'd4);

        // Streaming: 17 pushes with continuous pops, then drain -> 17 pops.
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 32'h0000_0100 + i, 5'((i % 31) + 1), 1'b1, 1'b1, 1'b0);
        end
        step(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("sat_cnt_w4", {60'd0, s_retire_cnt}, 64'hF);
        chk("cnt_w16_21", {48'd0, bus.retire_cnt}, 64'd21);

        // Fill to FULL, then assert reset asynchronously mid-cycle.
        step(1'b1, 32'h8000_0000, 5'd8, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0055, 5'd9, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_state", {62'd0, bus.dbg_state}, {62'd0, FULL});
        chk("pre_rst_neg", {63'd0, bus.out_neg}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("arst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("arst_out_result", {32'd0, bus.out_result}, 64'd0);
        chk("arst_out_rd", {59'd0, bus.out_rd}, 64'd0);
        chk("arst_out_we", {63'd0, bus.out_we}, 64'd0);
        chk("arst_out_zero", {63'd0, bus.out_zero}, 64'd0);
        chk("arst_out_neg", {63'd0, bus.out_neg}, 64'd0);
        chk("arst_retire_cnt", {48'd0, bus.retire_cnt}, 64'd0);
        chk("arst_retire_cnt_w4", {60'd0, s_retire_cnt}, 64'd0);
        chk("arst_state", {62'd0, bus.dbg_state}, {62'd0, EMPTY});
        exp_q.delete();
        exp_cnt = 0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("rst_push_ignored", {63'd0, bus.out_valid}, 64'd0);
        rst_n = 1'b1;

        // Back in service after reset.
        step(1'b1, 32'h0000_0005, 5'd4, 1'b1, 1'b0, 1'b0);
        chk("post_rst_result", {32'd0, bus.out_result}, 64'd5);
        step(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("post_rst_empty", {63'd0, bus.out_valid}, 64'd0);

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
